mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares one single-port main memory between the instruction-fetch requester and the load/store (data) requester. Each access runs through a three-state sequence: arbitrate, drive the memory, return the response. Data accesses have priority over fetch. An optional starvation guard forces a fetch grant after a bounded run of data grants. The block sits between the PC/issue-register logic, the memory-stage control and the main memory. It replaces stage-counter-based memory port selection with a req/ack handshake.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STREAK_MAX`, default 4: maximum consecutive data grants while fetch waits. Legal range is 1..15. Used only with the guard enabled.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `f_req`  in  1: fetch request; must be held until `f_ack`.
- `f_addr`  in  ADDR_W: fetch address; stable while `f_req` is high.
- `f_ack`  out  1: one-cycle pulse; fetch response valid.
- `f_rdata`  out  DATA_W: fetch read data; valid with `f_ack` and held until the next fetch ack.
- `d_req`  in  1: data request; must be held until `d_ack`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: data to write.
- `d_ack`  out  1: one-cycle pulse; data access complete.
- `d_rdata`  out  DATA_W: data read result; updated only by data reads.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_wen`  out  1: memory write enable.
- `mem_rdata`  in  DATA_W: memory read data, combinational from `mem_addr`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If no request is pending, remain in IDLE.
  - Otherwise latch the winner, its address, `d_we` and `d_wdata` into internal registers, then go to ACCESS.
- **Winner selection:**
  - Only `d_req` high: data wins.
  - Only `f_req` high: fetch wins.
  - Both high: data wins, except that fetch wins when the guard fires (see Configuration).
- **ACCESS:**
  - `mem_addr` is driven from the latched address.
  - `mem_wen` is 1 only for a data write. `mem_wdata` is the latched write data.
  - On the closing edge, `mem_rdata` is captured into `f_rdata` (fetch) or `d_rdata` (data read). Data writes capture nothing.
  - Next state is RESP.
- **RESP:**
  - Pulse the winner's ack for exactly one cycle.
  - Next state is IDLE.
  - Requests are not sampled in RESP. A requester that drops its req on the ack edge is never granted twice.
- **Outside ACCESS:** `mem_addr`=0, `mem_wdata`=0, `mem_wen`=0.
- **Sampling:** requests are sampled only in IDLE. A request arriving during ACCESS or RESP waits.
- **Protocol violation:** a req deasserted before its ack does not abort an access already in progress.
- **Throughput:** one access per 3 cycles.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE and the streak counter is 0. Reset takes effect immediately, including in the middle of an access.
- **Reset during ACCESS:** `mem_wen` drops asynchronously. The pending ack is never issued and no rdata is updated.
- **Latency:** request sampled at edge E0 (IDLE → ACCESS). The memory is driven during cycle 1. The ack is high during cycle 2, i.e. after edge E1. `busy` is high during cycles 1 and 2.
- **Write timing:** the memory write commits on edge E1.
- **Read data:** valid on the same cycle the ack rises.

## Configuration
- **Macro:** `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A 4-bit streak counter runs.
  - The counter increments on each data grant made while `f_req` is high, saturating at `STREAK_MAX`.
  - It clears to 0 on any fetch grant, and on any data grant made with `f_req` low.
  - When both requests are high and the counter equals `STREAK_MAX`, fetch wins.
- **Not defined:**
  - Strict data priority; no counter logic is present.
  - Fetch can starve indefinitely under continuous `d_req`.

## Test plan
- **Fetch-only read:** preload mem[0x10]=0xDEADBEEF; `f_req`=1, `f_addr`=0x10 at E0 → `f_ack`=1 in cycle 2 with `f_rdata`=0xDEADBEEF; `busy` high for 2 cycles.
- **Data write then read:** write 0x12345678 to 0x20 → `mem_wen` high for exactly one cycle; a subsequent read of 0x20 returns `d_rdata`=0x12345678 and leaves `f_rdata` unchanged.
- **Simultaneous requests:** `f_req` and `d_req` both high in IDLE → `d_ack` first; `f_ack` follows 3 cycles later.
- **Guard enabled, `STREAK_MAX`=4:** `d_req` held continuously and re-raised after every ack, with `f_req` high → grant order D,D,D,D,F,D… and the counter reads 0 after the fetch grant.
- **Guard disabled:** the same stimulus → `f_ack` never asserted over 50 grants.
- **Reset mid-ACCESS:** assert `rst` during a write ACCESS → `mem_wen`=0 immediately, no `d_ack` pulse, state IDLE; the request is re-served after `rst` deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, data first.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STREAK_MAX back-to-back data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : g_bad_streak
    $error("STREAK_MAX must lie in 1..15");
  end

  state_t            state, state_nxt;
  logic              grant, grant_data, guard_fire;
  logic              sel_data_p1, we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] wdata_p1;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] streak;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= 4'(STREAK_MAX)) return 4'(STREAK_MAX);
    return v + 4'd1;
  endfunction

  assign guard_fire = f_req && (streak == 4'(STREAK_MAX));

  // Only data grants made while fetch is waiting extend the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (grant) begin
      if (grant_data && f_req) streak <= sat_inc(streak);
      else                     streak <= '0;
    end
  end
`else
  assign guard_fire = 1'b0;
`endif

  assign grant      = (state == IDLE) && (f_req || d_req);
  assign grant_data = d_req && !guard_fire;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: arbitration result and request fields latched on the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel_data_p1 <= 1'b0;
      we_p1       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel_data_p1 <= grant_data;
        we_p1       <= grant_data && d_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      addr_p1  <= grant_data ? d_addr : f_addr;
      wdata_p1 <= d_wdata;
    end
  end

  // p1 -> p2: memory read data captured at the end of ACCESS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (state == ACCESS) begin
      if (!sel_data_p1)    f_rdata <= mem_rdata;
      else if (!we_p1)     d_rdata <= mem_rdata;
    end
  end

  // Outputs decode from state so reset clears them without waiting for a clock.
  assign busy      = (state != IDLE);
  assign mem_addr  = (state == ACCESS) ? addr_p1  : '0;
  assign mem_wdata = (state == ACCESS) ? wdata_p1 : '0;
  assign mem_wen   = (state == ACCESS) && sel_data_p1 && we_p1;
  assign f_ack     = (state == RESP) && !sel_data_p1;
  assign d_ack     = (state == RESP) && sel_data_p1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_port_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
  logic        f_ack, d_ack, mem_wen, busy;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int passes = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (pl_en)        mem[pl_addr] <= pl_data;
    else if (mem_wen) mem[mem_addr[7:0]] <= mem_wdata;
  end

  function automatic logic [31:0] rnd_addr();
    return $urandom & 32'hF000_000F;
  endfunction

  task automatic load(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v; ref_mem[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %0b want 0", busy); else passes++;
    checks++; if ({f_ack, d_ack, mem_wen} !== 3'b000) $display("FAIL rst_acks: got %b want 000", {f_ack, d_ack, mem_wen}); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passes++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passes++;
    checks++; if (f_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rst_rdata: got %h/%h want 0/0", f_rdata, d_rdata); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_fetch_read();
    load(8'h10, 32'hDEADBEEF);
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h10;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL fetch_busy_c1: got %0b want 1", busy); else passes++;
    checks++; if (mem_addr !== 32'h10) $display("FAIL fetch_mem_addr: got %h want 10", mem_addr); else passes++;
    checks++; if (f_ack !== 1'b0 || mem_wen !== 1'b0) $display("FAIL fetch_c1_ctl: got ack %0b wen %0b want 0 0", f_ack, mem_wen); else passes++;
    @(posedge clk); #1;
    checks++; if (f_ack !== 1'b1 || d_ack !== 1'b0) $display("FAIL fetch_ack: got f %0b d %0b want 1 0", f_ack, d_ack); else passes++;
    checks++; if (f_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got %h want deadbeef", f_rdata); else passes++;
    checks++; if (busy !== 1'b1 || mem_addr !== 32'h0) $display("FAIL fetch_c2: got busy %0b addr %h want 1 0", busy, mem_addr); else passes++;
    f_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || f_ack !== 1'b0) $display("FAIL fetch_done: got busy %0b ack %0b want 0 0", busy, f_ack); else passes++;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(posedge clk); #1;
    checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678)
      $display("FAIL wr_drive: got wen %0b addr %h data %h want 1 20 12345678", mem_wen, mem_addr, mem_wdata); else passes++;
    @(posedge clk); #1;
    checks++; if (d_ack !== 1'b1 || mem_wen !== 1'b0) $display("FAIL wr_ack: got ack %0b wen %0b want 1 0", d_ack, mem_wen); else passes++;
    checks++; if (mem[8'h20] !== 32'h12345678) $display("FAIL wr_commit: got %h want 12345678", mem[8'h20]); else passes++;
    checks++; if (d_rdata !== 32'h0) $display("FAIL wr_no_rdata: got %h want 0", d_rdata); else passes++;
    ref_mem[8'h20] = 32'h12345678;
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h20;
    @(posedge clk); #1;
    checks++; if (mem_wen !== 1'b0) $display("FAIL rd_wen: got %0b want 0", mem_wen); else passes++;
    @(posedge clk); #1;
    checks++; if (d_ack !== 1'b1 || d_rdata !== 32'h12345678) $display("FAIL rd_data: got ack %0b data %h want 1 12345678", d_ack, d_rdata); else passes++;
    checks++; if (f_rdata !== 32'hDEADBEEF) $display("FAIL rd_f_hold: got %h want deadbeef", f_rdata); else passes++;
    d_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    f_req = 1'b1; f_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if ({d_ack, f_ack} !== 2'b10) $display("FAIL sim_first: got d %0b f %0b want 1 0", d_ack, f_ack); else passes++;
    d_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if ({d_ack, f_ack} !== 2'b00) $display("FAIL sim_gap%0d: got d %0b f %0b want 0 0", i, d_ack, f_ack); else passes++;
    end
    @(posedge clk); #1;
    checks++; if ({d_ack, f_ack} !== 2'b01) $display("FAIL sim_second: got d %0b f %0b want 0 1", d_ack, f_ack); else passes++;
    f_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_starvation();
    int n;
    bit exp_fetch;
    do_reset();
    f_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0; f_req = 1'b1; d_req = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 50; c++) begin
      @(posedge clk); #1;
      if (f_ack || d_ack) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_fetch = (n % (SM + 1)) == SM;
`else
        exp_fetch = 1'b0;
`endif
        checks++; if ({f_ack, d_ack} !== {exp_fetch, !exp_fetch})
          $display("FAIL starve_order grant %0d: got f %0b d %0b want f %0b", n, f_ack, d_ack, exp_fetch); else passes++;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (exp_fetch) begin
          checks++; if (dut.streak !== 4'd0) $display("FAIL starve_counter: got %0d want 0", dut.streak); else passes++;
        end
`endif
        n++;
      end
    end
    checks++; if (n != 50) $display("FAIL starve_count: got %0d grants want 50", n); else passes++;
    f_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_access();
    load(8'h30, 32'h11112222);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    checks++; if (mem_wen !== 1'b1) $display("FAIL rma_wen_before: got %0b want 1", mem_wen); else passes++;
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_wen !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL rma_async: got wen %0b busy %0b addr %h want 0 0 0", mem_wen, busy, mem_addr); else passes++;
    checks++; if (f_rdata !== 32'h0) $display("FAIL rma_f_rdata: got %h want 0", f_rdata); else passes++;
    @(posedge clk); #1;
    checks++; if (d_ack !== 1'b0) $display("FAIL rma_no_ack: got %0b want 0", d_ack); else passes++;
    checks++; if (mem[8'h30] !== 32'h11112222) $display("FAIL rma_no_write: got %h want 11112222", mem[8'h30]); else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_wen !== 1'b1 || busy !== 1'b1) $display("FAIL rma_reserve: got wen %0b busy %0b want 1 1", mem_wen, busy); else passes++;
    @(posedge clk); #1;
    checks++; if (d_ack !== 1'b1 || mem[8'h30] !== 32'hCAFEF00D)
      $display("FAIL rma_complete: got ack %0b mem %h want 1 cafef00d", d_ack, mem[8'h30]); else passes++;
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_random();
    int g, nfree, strk;
    bit w_data, w_we;
    logic [31:0] w_addr, w_wdata, exp_f, exp_d;
    do_reset();
    for (int i = 0; i < 16; i++) load(8'(i), $urandom);
    g = -10; nfree = 0; strk = 0; exp_f = '0; exp_d = '0;
    w_data = 1'b0; w_we = 1'b0; w_addr = '0; w_wdata = '0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      if (k >= nfree && (f_req || d_req)) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        w_data = d_req && !(f_req && strk == SM);
        if (w_data && f_req) strk = (strk < SM) ? strk + 1 : SM;
        else                 strk = 0;
`else
        w_data = d_req;
`endif
        w_we = w_data && d_we;
        w_addr = w_data ? d_addr : f_addr;
        w_wdata = d_wdata;
        g = k; nfree = k + 3;
      end
      if (k == g + 1) begin
        if (w_we)        ref_mem[w_addr[7:0]] = w_wdata;
        else if (w_data) exp_d = ref_mem[w_addr[7:0]];
        else             exp_f = ref_mem[w_addr[7:0]];
      end
      #1;
      checks++; if (busy !== (k == g || k == g + 1)) $display("FAIL rnd_busy c%0d: got %0b", k, busy); else passes++;
      checks++; if ({f_ack, d_ack} !== {(k == g + 1) && !w_data, (k == g + 1) && w_data})
        $display("FAIL rnd_ack c%0d: got f %0b d %0b want f %0b d %0b", k, f_ack, d_ack, (k == g + 1) && !w_data, (k == g + 1) && w_data); else passes++;
      checks++; if (mem_wen !== (k == g && w_we)) $display("FAIL rnd_wen c%0d: got %0b", k, mem_wen); else passes++;
      checks++; if (mem_addr !== ((k == g) ? w_addr : 32'h0)) $display("FAIL rnd_addr c%0d: got %h", k, mem_addr); else passes++;
      if (k == g && w_we) begin
        checks++; if (mem_wdata !== w_wdata) $display("FAIL rnd_wdata c%0d: got %h want %h", k, mem_wdata, w_wdata); else passes++;
      end
      checks++; if (f_rdata !== exp_f) $display("FAIL rnd_f_rdata c%0d: got %h want %h", k, f_rdata, exp_f); else passes++;
      checks++; if (d_rdata !== exp_d) $display("FAIL rnd_d_rdata c%0d: got %h want %h", k, d_rdata, exp_d); else passes++;
      if (k == g + 1 && !w_data) begin
        f_req = 1'($urandom_range(0, 1)); f_addr = rnd_addr();
      end else if (!f_req && $urandom_range(0, 3) == 0) begin
        f_req = 1'b1; f_addr = rnd_addr();
      end
      if (k == g + 1 && w_data) begin
        d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
      end else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rnd_addr(); d_wdata = $urandom;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_read();
    test_simultaneous();
    test_reset_mid_access();
    test_starvation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
